// File: rtl/fb_arb_pkg.sv
// Shared types and helpers for the framebuffer port arbiter.
// Holds flush states, requester indices and pixel clip/address math.
package fb_arb_pkg;

    typedef enum logic [1:0] {
        FL_IDLE  = 2'd0,
        FL_FLUSH = 2'd1,
        FL_DONE  = 2'd2
    } flush_state_e;

    localparam logic REQ_ACC  = 1'b0;
    localparam logic REQ_HOST = 1'b1;

    // Off-screen test: negative coordinates or beyond the visible window.
    function automatic logic pix_clipped(
        input logic [15:0] x,
        input logic [15:0] y,
        input logic [16:0] fb_w,
        input logic [16:0] fb_h
    );
        return x[15] | y[15] |
               ({1'b0, x} >= fb_w) |
               ({1'b0, y} >= fb_h);
    endfunction

    // Linear address {y, x}; caller truncates to its address width.
    function automatic logic [31:0] pix_addr(
        input logic [15:0] x,
        input logic [15:0] y,
        input int          xb,
        input int          yb
    );
        logic [31:0] xm;
        logic [31:0] ym;
        xm = {16'd0, x} & ((32'd1 << xb) - 32'd1);
        ym = {16'd0, y} & ((32'd1 << yb) - 32'd1);
        return (ym << xb) | xm;
    endfunction

endpackage

// File: rtl/fb_pix_fifo.sv
// Small synchronous FIFO for accelerator pixels ({addr, data}).
// Supports push and pop in the same cycle, including while full.
module fb_pix_fifo #(
    parameter int DW    = 24,
    parameter int DEPTH = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          pop_i,
    output logic [DW-1:0] rdata_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int PW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW:0]   wr_q, wr_d;
    logic [PW:0]   rd_q, rd_d;
    logic          do_push, do_pop;

    // Pointer bookkeeping; a push into a full FIFO only lands if a pop frees a slot.
    always_comb begin
        empty_o = (wr_q == rd_q);
        full_o  = (wr_q[PW] != rd_q[PW]) &&
                  (wr_q[PW-1:0] == rd_q[PW-1:0]);
        do_pop  = pop_i & ~empty_o;
        do_push = push_i & (~full_o | do_pop);
        wr_d    = do_push ? wr_q + 1'b1 : wr_q;
        rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
        rdata_o = mem_q[rd_q[PW-1:0]];
    end

    // Pointer registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage array, written at the write pointer.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q[PW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/fb_port_arbiter.sv
// Framebuffer SRAM port arbiter: scan-out reads, accelerator and host writes.
// Clips off-screen pixels, counts drops and drains on flush request.
module fb_port_arbiter
    import fb_arb_pkg::*;
#(
    parameter int X_BITS     = 8,
    parameter int Y_BITS     = 8,
    parameter int FB_W       = 256,
    parameter int FB_H       = 200,
    parameter int PIX_WIDTH  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     ACLK,
    input  logic                     RESET,
    input  logic [15:0]              acc_x,
    input  logic [15:0]              acc_y,
    input  logic                     acc_we,
    input  logic [PIX_WIDTH-1:0]     acc_data,
    input  logic                     h_valid,
    input  logic [15:0]              h_x,
    input  logic [15:0]              h_y,
    input  logic [PIX_WIDTH-1:0]     h_data,
    output logic                     h_ready,
    input  logic                     rd_req,
    input  logic [X_BITS+Y_BITS-1:0] rd_addr,
    output logic                     rd_rvalid,
    output logic [PIX_WIDTH-1:0]     rd_rdata,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [X_BITS+Y_BITS-1:0] mem_addr,
    output logic [PIX_WIDTH-1:0]     mem_wdata,
    input  logic [PIX_WIDTH-1:0]     mem_rdata,
    input  logic                     flush_req,
    output logic                     flush_done,
    output logic                     fifo_ovf,
    output logic [15:0]              drop_cnt,
    input  logic                     cnt_clr
);

    localparam int AW = X_BITS + Y_BITS;
    localparam int FW = AW + PIX_WIDTH;

    logic                 acc_clip, h_clip;
    logic                 acc_ok, h_ok;
    logic [AW-1:0]        acc_addr, h_addr;
    logic                 fifo_full, fifo_empty;
    logic [FW-1:0]        fifo_rdata;
    logic [AW-1:0]        fifo_addr;
    logic [PIX_WIDTH-1:0] fifo_data;
    logic                 gnt_rd, gnt_w0, gnt_w1;

    logic                 rr_last_q, rr_last_d;
    logic                 mem_en_q, mem_en_d;
    logic                 mem_we_q, mem_we_d;
    logic [AW-1:0]        mem_addr_q, mem_addr_d;
    logic [PIX_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                 mem_w0_q, mem_w0_d;
    logic                 rvalid_q, rvalid_d;
    logic                 ovf_q, ovf_d;
    logic [15:0]          drop_q, drop_d;
    logic [1:0]           drop_inc;
    logic [16:0]          drop_sum;
    flush_state_e         fl_q, fl_d;

    fb_pix_fifo #(
        .DW    (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (ACLK),
        .rst_i   (RESET),
        .push_i  (acc_ok),
        .wdata_i ({acc_addr, acc_data}),
        .pop_i   (gnt_w0),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Clip, address and arbitration for this cycle's requests.
    always_comb begin
        acc_clip  = pix_clipped(acc_x, acc_y, 17'(FB_W), 17'(FB_H));
        h_clip    = pix_clipped(h_x, h_y, 17'(FB_W), 17'(FB_H));
        acc_addr  = AW'(pix_addr(acc_x, acc_y, X_BITS, Y_BITS));
        h_addr    = AW'(pix_addr(h_x, h_y, X_BITS, Y_BITS));
        acc_ok    = acc_we & ~acc_clip;
        h_ok      = h_valid & ~h_clip;
        fifo_addr = fifo_rdata[FW-1:PIX_WIDTH];
        fifo_data = fifo_rdata[PIX_WIDTH-1:0];

        gnt_rd = rd_req;
        gnt_w0 = 1'b0;
        gnt_w1 = 1'b0;
        if (!rd_req) begin
            if (!fifo_empty && h_ok) begin
                gnt_w0 = (rr_last_q == REQ_HOST);
                gnt_w1 = (rr_last_q == REQ_ACC);
            end else begin
                gnt_w0 = ~fifo_empty;
                gnt_w1 = h_ok;
            end
        end

        h_ready = gnt_w1 | (h_valid & h_clip);
    end

    // Next state of the registered memory stage and the round-robin pointer.
    always_comb begin
        mem_en_d    = gnt_rd | gnt_w0 | gnt_w1;
        mem_we_d    = gnt_w0 | gnt_w1;
        mem_w0_d    = gnt_w0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        if (gnt_rd) begin
            mem_addr_d = rd_addr;
        end else if (gnt_w0) begin
            mem_addr_d  = fifo_addr;
            mem_wdata_d = fifo_data;
        end else if (gnt_w1) begin
            mem_addr_d  = h_addr;
            mem_wdata_d = h_data;
        end

        rr_last_d = rr_last_q;
        if (gnt_w0) begin
            rr_last_d = REQ_ACC;
        end else if (gnt_w1) begin
            rr_last_d = REQ_HOST;
        end

        rvalid_d = mem_en_q & ~mem_we_q;
    end

    // Sticky overflow and saturating drop counter; clear wins over increments.
    always_comb begin
        drop_inc = {1'b0, acc_we & acc_clip} + {1'b0, h_valid & h_clip};
        drop_sum = {1'b0, drop_q} + {15'd0, drop_inc};
        ovf_d    = ovf_q | (acc_ok & fifo_full & ~gnt_w0);
        drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        if (cnt_clr) begin
            ovf_d  = 1'b0;
            drop_d = '0;
        end
    end

    // Flush sequencing: wait until no accelerator pixel is queued or in the memory stage.
    always_comb begin
        fl_d = fl_q;
        unique case (fl_q)
            FL_IDLE:  if (flush_req) fl_d = FL_FLUSH;
            FL_FLUSH: if (fifo_empty && !mem_w0_q) fl_d = FL_DONE;
            FL_DONE:  fl_d = FL_IDLE;
            default:  fl_d = FL_IDLE;
        endcase
    end

    // State registers.
    always_ff @(posedge ACLK) begin
        if (RESET) begin
            rr_last_q   <= REQ_HOST;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_w0_q    <= 1'b0;
            rvalid_q    <= 1'b0;
            ovf_q       <= 1'b0;
            drop_q      <= '0;
            fl_q        <= FL_IDLE;
        end else begin
            rr_last_q   <= rr_last_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_w0_q    <= mem_w0_d;
            rvalid_q    <= rvalid_d;
            ovf_q       <= ovf_d;
            drop_q      <= drop_d;
            fl_q        <= fl_d;
        end
    end

    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign rd_rvalid  = rvalid_q;
    assign rd_rdata   = rvalid_q ? mem_rdata : '0;
    assign fifo_ovf   = ovf_q;
    assign drop_cnt   = drop_q;
    assign flush_done = (fl_q == FL_DONE);

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Scoreboard bench for fb_port_arbiter: directed stimulus queues expected
// SRAM writes and read returns; a monitor compares them as they appear.
module tb_fb_port_arbiter;

    logic        ACLK;
    logic        RESET;
    logic [15:0] acc_x, acc_y;
    logic        acc_we;
    logic [7:0]  acc_data;
    logic        h_valid;
    logic [15:0] h_x, h_y;
    logic [7:0]  h_data;
    logic        h_ready;
    logic        rd_req;
    logic [15:0] rd_addr;
    logic        rd_rvalid;
    logic [7:0]  rd_rdata;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        flush_req, flush_done;
    logic        fifo_ovf;
    logic [15:0] drop_cnt;
    logic        cnt_clr;

    fb_port_arbiter dut (
        .ACLK       (ACLK),
        .RESET      (RESET),
        .acc_x      (acc_x),
        .acc_y      (acc_y),
        .acc_we     (acc_we),
        .acc_data   (acc_data),
        .h_valid    (h_valid),
        .h_x        (h_x),
        .h_y        (h_y),
        .h_data     (h_data),
        .h_ready    (h_ready),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_rvalid  (rd_rvalid),
        .rd_rdata   (rd_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .flush_req  (flush_req),
        .flush_done (flush_done),
        .fifo_ovf   (fifo_ovf),
        .drop_cnt   (drop_cnt),
        .cnt_clr    (cnt_clr)
    );

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        int          due;
    } wexp_t;

    typedef struct {
        logic [7:0] data;
        int         due;
    } rexp_t;

    wexp_t wq[$];
    rexp_t rq[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // SRAM model: read data is the low address byte, one cycle after the read.
    initial mem_rdata = 8'h00;
    always @(posedge ACLK) begin
        if (mem_en && !mem_we) mem_rdata <= mem_addr[7:0];
    end

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pop and compare on every write and every read return.
    initial begin
        wexp_t we;
        rexp_t re;
        forever begin
            @(posedge ACLK);
            cyc++;
            #1;
            if (mem_en && mem_we) begin
                if (wq.size() == 0) begin
                    check("unexpected_write", 32'(mem_addr), 32'hFFFFFFFF);
                end else begin
                    we = wq.pop_front();
                    check("wr_addr", 32'(mem_addr), 32'(we.addr));
                    check("wr_data", 32'(mem_wdata), 32'(we.data));
                    check("wr_cycle", 32'(cyc), 32'(we.due));
                end
            end
            if (rd_rvalid) begin
                if (rq.size() == 0) begin
                    check("unexpected_rvalid", 32'(rd_rdata), 32'hFFFFFFFF);
                end else begin
                    re = rq.pop_front();
                    check("rd_data", 32'(rd_rdata), 32'(re.data));
                    check("rd_cycle", 32'(cyc), 32'(re.due));
                end
            end
        end
    end

    task automatic idle();
        acc_x = 0; acc_y = 0; acc_we = 0; acc_data = 0;
        h_valid = 0; h_x = 0; h_y = 0; h_data = 0;
        rd_req = 0; rd_addr = 0;
        flush_req = 0; cnt_clr = 0;
    endtask

    task automatic nxt(int n);
        repeat (n) @(negedge ACLK);
    endtask

    initial begin
        int base;
        int n;
        int at;

        RESET = 1'b1;
        idle();
        nxt(3);
        #1;
        check("rst_mem_en", 32'(mem_en), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_wdata", 32'(mem_wdata), 0);
        check("rst_rvalid", 32'(rd_rvalid), 0);
        check("rst_rdata", 32'(rd_rdata), 0);
        check("rst_flush_done", 32'(flush_done), 0);
        check("rst_fifo_ovf", 32'(fifo_ovf), 0);
        check("rst_drop_cnt", 32'(drop_cnt), 0);
        check("rst_h_ready", 32'(h_ready), 0);
        nxt(1);
        RESET = 1'b0;
        nxt(2);

        // Single accelerator pixel: reaches memory two cycles later.
        acc_we = 1; acc_x = 3; acc_y = 2; acc_data = 8'h5A;
        wq.push_back('{16'h0203, 8'h5A, cyc + 2});
        nxt(1);
        idle();
        nxt(4);

        // Pipelined reads block a waiting host write.
        for (int i = 0; i < 3; i++) begin
            rd_req = 1; rd_addr = 16'(i);
            h_valid = 1; h_x = 5; h_y = 1; h_data = 8'h77;
            rq.push_back('{8'(i), cyc + 2});
            #1 check("h_ready_blocked", 32'(h_ready), 0);
            nxt(1);
        end
        rd_req = 0;
        #1 check("h_ready_after_rd", 32'(h_ready), 1);
        wq.push_back('{16'h0105, 8'h77, cyc + 1});
        nxt(1);
        idle();
        nxt(4);

        // Round robin after reset: ACC, HOST, ACC, HOST, then the last ACC.
        RESET = 1;
        nxt(1);
        RESET = 0;
        for (int i = 0; i < 3; i++) begin
            rd_req = 1; rd_addr = 16'h10 + 16'(i);
            acc_we = 1; acc_x = 16'd10 + 16'(i); acc_y = 3;
            acc_data = 8'hA0 + 8'(i);
            rq.push_back('{8'h10 + 8'(i), cyc + 2});
            nxt(1);
        end
        idle();
        base = cyc;
        wq.push_back('{16'h030A, 8'hA0, base + 1});
        wq.push_back('{16'h0414, 8'hC0, base + 2});
        wq.push_back('{16'h030B, 8'hA1, base + 3});
        wq.push_back('{16'h0415, 8'hC1, base + 4});
        wq.push_back('{16'h030C, 8'hA2, base + 5});
        for (int j = 0; j < 4; j++) begin
            h_valid = 1; h_x = 16'd20 + 16'(j / 2); h_y = 4;
            h_data = 8'hC0 + 8'(j / 2);
            #1 check("h_ready_rr", 32'(h_ready), 32'(j % 2));
            nxt(1);
        end
        idle();
        nxt(6);

        // Overflow under read starvation: 5 pixels, the first 4 survive.
        for (int i = 0; i < 6; i++) begin
            if (i == 4) check("ovf_before", 32'(fifo_ovf), 0);
            if (i == 5) check("ovf_after", 32'(fifo_ovf), 1);
            rd_req = 1; rd_addr = 16'h20 + 16'(i);
            rq.push_back('{8'h20 + 8'(i), cyc + 2});
            acc_we = (i < 5); acc_x = 16'(i); acc_y = 5;
            acc_data = 8'hB0 + 8'(i);
            nxt(1);
        end
        idle();
        for (int k = 0; k < 4; k++)
            wq.push_back('{16'h0500 + 16'(k), 8'hB0 + 8'(k), cyc + 1 + k});
        nxt(7);

        // Clipping and counters.
        cnt_clr = 1;
        nxt(1);
        idle();
        #1;
        check("ovf_cleared", 32'(fifo_ovf), 0);
        check("drop_cleared", 32'(drop_cnt), 0);
        acc_we = 1; acc_x = 16'hFFFF; acc_y = 0;
        h_valid = 1; h_x = 16'd256; h_y = 0; h_data = 8'h11;
        #1 check("h_ready_clip", 32'(h_ready), 1);
        nxt(1);
        idle();
        acc_we = 1; acc_x = 0; acc_y = 16'd200;
        nxt(1);
        idle();
        nxt(1);
        check("drop_cnt_3", 32'(drop_cnt), 3);
        h_valid = 1; h_x = 16'd255; h_y = 16'd199; h_data = 8'h5E;
        acc_we = 1; acc_x = 16'd254; acc_y = 16'd199; acc_data = 8'h5F;
        wq.push_back('{16'hC7FF, 8'h5E, cyc + 1});
        wq.push_back('{16'hC7FE, 8'h5F, cyc + 2});
        #1 check("h_ready_edge", 32'(h_ready), 1);
        nxt(1);
        idle();
        nxt(3);
        check("drop_edge_inrange", 32'(drop_cnt), 3);
        cnt_clr = 1; acc_we = 1; acc_x = 16'd300; acc_y = 0;
        nxt(1);
        idle();
        nxt(1);
        check("clr_priority", 32'(drop_cnt), 0);
        acc_we = 1; acc_x = 16'hFFFF;
        h_valid = 1; h_x = 16'd256;
        nxt(32767);
        check("drop_fffe", 32'(drop_cnt), 32'hFFFE);
        nxt(1);
        check("drop_sat", 32'(drop_cnt), 32'hFFFF);
        nxt(1);
        check("drop_hold", 32'(drop_cnt), 32'hFFFF);
        idle();
        cnt_clr = 1;
        nxt(1);
        idle();
        nxt(2);

        // Flush with 3 queued pixels; a repeat request while flushing is ignored.
        for (int i = 0; i < 3; i++) begin
            rd_req = 1; rd_addr = 16'h30 + 16'(i);
            rq.push_back('{8'h30 + 8'(i), cyc + 2});
            acc_we = 1; acc_x = 16'd40 + 16'(i); acc_y = 6;
            acc_data = 8'hD0 + 8'(i);
            nxt(1);
        end
        idle();
        base = cyc;
        flush_req = 1;
        for (int k = 0; k < 3; k++)
            wq.push_back('{16'h0628 + 16'(k), 8'hD0 + 8'(k), base + 1 + k});
        nxt(1);
        flush_req = 0;
        n = 0;
        at = -1;
        for (int k = 0; k < 10; k++) begin
            flush_req = (k == 1);
            if (flush_done) begin
                n++;
                at = cyc;
            end
            nxt(1);
        end
        idle();
        check("flush_pulses", 32'(n), 1);
        // Last write shows at base+3, commits at the next edge, done one cycle later.
        check("flush_cycle", 32'(at), 32'(base + 5));

        // Reset while flushing: no done pulse, queued pixels and last read discarded.
        for (int i = 0; i < 4; i++) begin
            rd_req = 1; rd_addr = 16'h40 + 16'(i);
            if (i < 3) begin
                rq.push_back('{8'h40 + 8'(i), cyc + 2});
                acc_we = 1; acc_x = 16'd50 + 16'(i); acc_y = 7;
                acc_data = 8'hE0 + 8'(i);
            end else begin
                acc_we = 0;
                flush_req = 1;
            end
            nxt(1);
        end
        idle();
        RESET = 1;
        nxt(1);
        RESET = 0;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            if (flush_done) n++;
            nxt(1);
        end
        check("no_done_after_rst", 32'(n), 0);
        flush_req = 1;
        base = cyc;
        nxt(1);
        flush_req = 0;
        n = 0;
        at = -1;
        for (int k = 0; k < 6; k++) begin
            if (flush_done) begin
                n++;
                at = cyc;
            end
            nxt(1);
        end
        check("empty_flush_pulses", 32'(n), 1);
        check("empty_flush_cycle", 32'(at), 32'(base + 2));

        for (int k = 0; k < 50 && (wq.size() + rq.size()) != 0; k++) nxt(1);
        check("sb_leftover", 32'(wq.size() + rq.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
